arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- Encrypts a length-prefixed plaintext string in pt_mem into a length-prefixed ciphertext in ct_mem, using a 24-bit ARC4 key.
- It is the writer-side counterpart of crack: it produces the ct_mem images that crack reads, and it is used to build known-key regression vectors.
- Uses an external 256x8 S memory and single-port 1-cycle-read-latency RAMs (registered address, q valid next cycle).
- en/rdy handshake is identical to the other ARC4 blocks.

Parameters:
- KEY_BYTES, 3, key length in bytes; key bytes taken MSB-first from key.
- MAX_LEN, 255, maximum message length; the length byte is clamped to this value.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  start pulse; sampled only when rdy=1
- rdy  output  1  high in IDLE; ready to accept en
- key  input  24  ARC4 key; latched on the accepted en
- s_addr  output  8  S memory address
- s_rddata  input  8  S memory read data (1-cycle latency)
- s_wrdata  output  8  S memory write data
- s_wren  output  1  S memory write enable
- pt_addr  output  8  plaintext memory address
- pt_rddata  input  8  plaintext read data (1-cycle latency)
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable

Behaviour:
- Reset (async): rdy=1; all addresses, write data and write enables are 0; FSM enters IDLE; the latched key is cleared.
- Reset mid-operation: wren outputs drop immediately; the partial ct_mem contents are left undefined.
- Handshake: en && rdy latches key; rdy falls on the next edge. en while rdy=0 is ignored. rdy rises again the cycle after the final ct write.
- FSM states: IDLE -> INIT -> KSA_RDI -> KSA_WTI -> KSA_RDJ -> KSA_WTJ -> KSA_WRI -> KSA_WRJ (i<255 back to KSA_RDI, else) -> LEN_RD -> LEN_WT -> LEN_WR -> PRGA_* -> IDLE.
- INIT: 256 consecutive cycles with s_wren=1, s_addr=s_wrdata=i, i=0..255.
- KSA: j = j + S[i] + key_byte[i mod KEY_BYTES], mod 256; then swap S[i] and S[j].
  - key_byte[0] = key[23:16], key_byte[1] = key[15:8], key_byte[2] = key[7:0].
  - The swap writes S[i] first, then S[j].
  - When i==j the second write repeats the same value; this is harmless.
- LEN: read pt[0]; L = min(pt[0], MAX_LEN); write ct[0] = L. i and j reset to 0 before PRGA.
- PRGA, for k = 1..L:
  - i = i+1; read S[i]; j = j+S[i]; read S[j]; write S[i] = S[j]; write S[j] = old S[i].
  - Read S[(S[i]+S[j]) mod 256] as pad.
  - Read pt[k]; write ct[k] = pt[k] XOR pad.
  - Each ct write is a single-cycle ct_wren pulse.
- L=0: only ct[0]=0 is written; PRGA is skipped.
- All index arithmetic is 8-bit wrap-around. A k counter reaching 255 must not overflow the loop test; use a 9-bit compare.
- Only one memory is written per cycle. pt_mem is never written.

Optional Feature:
- Macro: ARC4_PRINTABLE_CHK_EN.
- With the macro defined:
  - Adds output pt_ok (1 bit), reset value 1 and cleared to 1 on each accepted en.
  - pt_ok is forced to 0 if any pt[k] (k=1..L) lies outside 0x20..0x7E.
  - pt_ok is valid when rdy rises and holds until the next en.
- Without the macro: the port and its logic are absent.

Decomposition:
- Package arc4_pkg:
  - FSM state enum.
  - Constants S_SIZE=256, PRINT_LO=8'h20, PRINT_HI=8'h7E.
  - Function key_byte(key, idx).
- Shared with crack.
- One natural sub-module, arc4_ksa: the INIT+KSA sequencer, driving the S port through a mux owned by the top level.

Test Plan:
- Reset, then key=24'h000018 with pt="" (pt[0]=0) -> ct[0]=0; exactly one ct_wren pulse; rdy high again.
- key=24'h000018 with pt = length 5, "hello" -> ct matches the bench ARC4 model; feeding the produced ct_mem to crack yields key=24'h000018 with key_valid=1.
- Check INIT timing: s_wren high for exactly 256 cycles after en, with s_wrdata=0..255 in order; after KSA, the S contents equal the model's S for key 24'h1E4600.
- Hold en high throughout an operation -> exactly one job runs; rdy=0 until done; no second job starts until the en is seen again with rdy=1.
- Pulse rst_n low during PRGA at k=3 -> ct_wren and s_wren drop that same cycle; rdy=1; a fresh job then completes correctly.
- With ARC4_PRINTABLE_CHK_EN, pt = length 3, bytes 41 0A 42 -> pt_ok=0; pt = "ABC" -> pt_ok=1.

Source files
------------

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_pkg
//  Description : Shared ARC4 definitions: FSM state encodings, S-box and
//                printable-range constants, key byte selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arc4_pkg;

    localparam int          S_SIZE        = 256;
    localparam logic [7:0]  PRINT_LO      = 8'h20;
    localparam logic [7:0]  PRINT_HI      = 8'h7E;
    // Widest key the helper function can select from
    localparam int          KEY_MAX_BYTES = 16;

    typedef logic [4:0] state_t;

    localparam state_t ST_IDLE      = 5'd0;
    localparam state_t ST_INIT      = 5'd1;
    localparam state_t ST_KSA_RDI   = 5'd2;
    localparam state_t ST_KSA_WTI   = 5'd3;
    localparam state_t ST_KSA_RDJ   = 5'd4;
    localparam state_t ST_KSA_WTJ   = 5'd5;
    localparam state_t ST_KSA_WRI   = 5'd6;
    localparam state_t ST_KSA_WRJ   = 5'd7;
    localparam state_t ST_LEN_RD    = 5'd8;
    localparam state_t ST_LEN_WT    = 5'd9;
    localparam state_t ST_LEN_WR    = 5'd10;
    localparam state_t ST_PRGA_RDI  = 5'd11;
    localparam state_t ST_PRGA_WTI  = 5'd12;
    localparam state_t ST_PRGA_RDJ  = 5'd13;
    localparam state_t ST_PRGA_WTJ  = 5'd14;
    localparam state_t ST_PRGA_WRI  = 5'd15;
    localparam state_t ST_PRGA_WRJ  = 5'd16;
    localparam state_t ST_PRGA_RDP  = 5'd17;
    localparam state_t ST_PRGA_WTP  = 5'd18;

    // Key bytes are taken MSB-first: idx 0 is the most significant byte of an
    // nbytes-wide key held right-justified in the argument.
    function automatic logic [7:0] key_byte(
        input logic [8*KEY_MAX_BYTES-1:0] key,
        input int unsigned                idx,
        input int unsigned                nbytes
    );
        return key[8*(nbytes-1-idx) +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_ksa.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_ksa
//  Description : ARC4 S-box initialisation and key-scheduling sequencer.
//                Supplies next state for INIT/KSA_* states and drives the
//                S-memory port while those states are active.
//  Revision    : 1.0 - initial release
// ============================================================================
module arc4_ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  state_t                 state,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output state_t                 next_state
);

    localparam logic [7:0] C_LAST_IDX = 8'(S_SIZE - 1);
    localparam logic [7:0] C_LAST_KB  = 8'(KEY_BYTES - 1);

    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_kidx;
    logic [7:0] w_kb;
    logic [8*KEY_MAX_BYTES-1:0] w_key_ext;

    assign w_key_ext = {{(8*(KEY_MAX_BYTES-KEY_BYTES)){1'b0}}, key};
    assign w_kb      = key_byte(w_key_ext, 32'(r_kidx), KEY_BYTES);

    // Sequencer transitions; the last swap hands over to the length phase
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:    next_state = (r_i == C_LAST_IDX) ? ST_KSA_RDI : ST_INIT;
            ST_KSA_RDI: next_state = ST_KSA_WTI;
            ST_KSA_WTI: next_state = ST_KSA_RDJ;
            ST_KSA_RDJ: next_state = ST_KSA_WTJ;
            ST_KSA_WTJ: next_state = ST_KSA_WRI;
            ST_KSA_WRI: next_state = ST_KSA_WRJ;
            ST_KSA_WRJ: next_state = (r_i == C_LAST_IDX) ? ST_LEN_RD : ST_KSA_RDI;
            default:    next_state = state;
        endcase
    end

    // S port drive: identity fill, then read i, read j, write S[i], write S[j]
    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        case (state)
            ST_INIT: begin
                s_addr   = r_i;
                s_wrdata = r_i;
                s_wren   = 1'b1;
            end
            ST_KSA_RDI: s_addr = r_i;
            ST_KSA_RDJ: s_addr = r_j;
            ST_KSA_WRI: begin
                s_addr   = r_i;
                s_wrdata = r_sj;
                s_wren   = 1'b1;
            end
            ST_KSA_WRJ: begin
                s_addr   = r_j;
                s_wrdata = r_si;
                s_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    // Index, key-position and swap operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i    <= 8'h00;
            r_j    <= 8'h00;
            r_si   <= 8'h00;
            r_sj   <= 8'h00;
            r_kidx <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    r_i    <= 8'h00;
                    r_j    <= 8'h00;
                    r_kidx <= 8'h00;
                end
                ST_INIT:    r_i <= r_i + 8'd1;
                ST_KSA_WTI: begin
                    r_si <= s_rddata;
                    r_j  <= r_j + s_rddata + w_kb;
                end
                ST_KSA_WTJ: r_sj <= s_rddata;
                ST_KSA_WRJ: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= (r_kidx == C_LAST_KB) ? 8'h00 : r_kidx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arc4_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_encrypt
//  Description : ARC4 encryption of a length-prefixed plaintext (pt_mem) into
//                a length-prefixed ciphertext (ct_mem) using an external S RAM.
//                Optional macro ARC4_PRINTABLE_CHK_EN adds the pt_ok output.
//  Revision    : 1.0 - initial release
// ============================================================================
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MAX_LEN   = 255
) (
`ifdef ARC4_PRINTABLE_CHK_EN
    output logic                   pt_ok,
`endif
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    localparam logic [7:0] C_MAX_LEN = 8'(MAX_LEN);

    state_t                 r_state;
    state_t                 w_next_state;
    state_t                 w_ksa_next;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_len;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [8:0]             r_k;        // 9 bits so k=255 compares cleanly
    logic [7:0]             w_ksa_addr;
    logic [7:0]             w_ksa_wrdata;
    logic                   w_ksa_wren;
    logic                   w_start;
    logic                   w_ksa_phase;
    logic                   w_last_byte;
    logic [7:0]             w_len_clamped;

    assign rdy           = (r_state == ST_IDLE);
    assign w_start       = en && rdy;
    assign w_ksa_phase   = (r_state >= ST_INIT) && (r_state <= ST_KSA_WRJ);
    assign w_last_byte   = (r_k == {1'b0, r_len});
    assign w_len_clamped = (pt_rddata > C_MAX_LEN) ? C_MAX_LEN : pt_rddata;

    arc4_ksa #(
        .KEY_BYTES (KEY_BYTES)
    ) u_ksa (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (r_state),
        .key        (r_key),
        .s_rddata   (s_rddata),
        .s_addr     (w_ksa_addr),
        .s_wrdata   (w_ksa_wrdata),
        .s_wren     (w_ksa_wren),
        .next_state (w_ksa_next)
    );

    // Top-level state transitions; INIT/KSA stepping is delegated to u_ksa
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:     w_next_state = en ? ST_INIT : ST_IDLE;
            ST_INIT, ST_KSA_RDI, ST_KSA_WTI, ST_KSA_RDJ,
            ST_KSA_WTJ, ST_KSA_WRI, ST_KSA_WRJ:
                         w_next_state = w_ksa_next;
            ST_LEN_RD:   w_next_state = ST_LEN_WT;
            ST_LEN_WT:   w_next_state = ST_LEN_WR;
            ST_LEN_WR:   w_next_state = (r_len == 8'h00) ? ST_IDLE : ST_PRGA_RDI;
            ST_PRGA_RDI: w_next_state = ST_PRGA_WTI;
            ST_PRGA_WTI: w_next_state = ST_PRGA_RDJ;
            ST_PRGA_RDJ: w_next_state = ST_PRGA_WTJ;
            ST_PRGA_WTJ: w_next_state = ST_PRGA_WRI;
            ST_PRGA_WRI: w_next_state = ST_PRGA_WRJ;
            ST_PRGA_WRJ: w_next_state = ST_PRGA_RDP;
            ST_PRGA_RDP: w_next_state = ST_PRGA_WTP;
            ST_PRGA_WTP: w_next_state = w_last_byte ? ST_IDLE : ST_PRGA_RDI;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Memory port mux: decoded from state so reset drops every enable at once
    always_comb begin
        s_addr    = 8'h00;
        s_wrdata  = 8'h00;
        s_wren    = 1'b0;
        pt_addr   = 8'h00;
        ct_addr   = 8'h00;
        ct_wrdata = 8'h00;
        ct_wren   = 1'b0;
        if (w_ksa_phase) begin
            s_addr   = w_ksa_addr;
            s_wrdata = w_ksa_wrdata;
            s_wren   = w_ksa_wren;
        end
        case (r_state)
            ST_LEN_WR: begin
                ct_wrdata = r_len;
                ct_wren   = 1'b1;
            end
            ST_PRGA_RDI: s_addr = r_i + 8'd1;
            ST_PRGA_RDJ: s_addr = r_j;
            ST_PRGA_WRI: begin
                s_addr   = r_i;
                s_wrdata = r_sj;
                s_wren   = 1'b1;
            end
            ST_PRGA_WRJ: begin
                s_addr   = r_j;
                s_wrdata = r_si;
                s_wren   = 1'b1;
            end
            // Pad and plaintext fetched together; both land in PRGA_WTP
            ST_PRGA_RDP: begin
                s_addr  = r_si + r_sj;
                pt_addr = r_k[7:0];
            end
            ST_PRGA_WTP: begin
                ct_addr   = r_k[7:0];
                ct_wrdata = pt_rddata ^ s_rddata;
                ct_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    // State, key latch and PRGA datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_len   <= 8'h00;
            r_i     <= 8'h00;
            r_j     <= 8'h00;
            r_si    <= 8'h00;
            r_sj    <= 8'h00;
            r_k     <= 9'd0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_key <= key;
            end
            case (r_state)
                ST_LEN_WT:   r_len <= w_len_clamped;
                ST_LEN_WR: begin
                    r_i <= 8'h00;
                    r_j <= 8'h00;
                    r_k <= 9'd1;
                end
                ST_PRGA_RDI: r_i <= r_i + 8'd1;
                ST_PRGA_WTI: begin
                    r_si <= s_rddata;
                    r_j  <= r_j + s_rddata;
                end
                ST_PRGA_WTJ: r_sj <= s_rddata;
                ST_PRGA_WTP: r_k  <= r_k + 9'd1;
                default: ;
            endcase
        end
    end

`ifdef ARC4_PRINTABLE_CHK_EN
    // Sticky flag: any plaintext byte outside 0x20..0x7E clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_ok <= 1'b1;
        end else if (w_start) begin
            pt_ok <= 1'b1;
        end else if (r_state == ST_PRGA_WTP &&
                     (pt_rddata < PRINT_LO || pt_rddata > PRINT_HI)) begin
            pt_ok <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arc4_encrypt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arc4_encrypt
//  Description : Scoreboard bench for arc4_encrypt with behavioural 1-cycle
//                latency S/pt/ct memories and an ARC4 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr, s_rddata, s_wrdata;
    logic        s_wren;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;
`ifdef ARC4_PRINTABLE_CHK_EN
    logic        pt_ok;
`endif

    arc4_encrypt dut (
`ifdef ARC4_PRINTABLE_CHK_EN
        .pt_ok     (pt_ok),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];

    // Single-port RAMs: address sampled at the edge, data valid the next cycle
    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata <= s_mem[s_addr];
    end
    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    int          assertions = 0;
    int          failures   = 0;
    int          ct_writes  = 0;
    logic [15:0] sb[$];
    logic [7:0]  m_s   [256];
    logic [7:0]  m_ksa [256];
    logic [7:0]  m_ct  [256];
    logic [7:0]  pt_img[256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ARC4: KSA then PRGA over pt_img[1..len]
    task automatic model(input logic [23:0] k, input int len);
        int         j;
        logic [7:0] t, kb, ii, jj;
        for (int i = 0; i < 256; i++) m_s[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j      = (j + int'(m_s[i]) + int'(kb)) % 256;
            t      = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
        end
        for (int i = 0; i < 256; i++) m_ksa[i] = m_s[i];
        ii = 8'h00;
        jj = 8'h00;
        m_ct[0] = 8'(len);
        for (int n = 1; n <= len; n++) begin
            ii       = ii + 8'd1;
            jj       = jj + m_s[ii];
            t        = m_s[ii];
            m_s[ii]  = m_s[jj];
            m_s[jj]  = t;
            t        = m_s[ii] + m_s[jj];
            m_ct[n]  = pt_img[n] ^ m_s[t];
        end
    endtask

    // Load pt memory, run the model and queue every expected ct write
    task automatic setup_job(input logic [23:0] k, input int len);
        pt_mem[0] = 8'(len);
        for (int n = 1; n <= len; n++) pt_mem[n] = pt_img[n];
        model(k, len);
        for (int n = 0; n <= len; n++) sb.push_back({8'(n), m_ct[n]});
        key       = k;
        ct_writes = 0;
    endtask

    task automatic start_job();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, rdy}, 32'h1);
    endtask

    // Monitor: every ct write is popped against the scoreboard
    always @(negedge clk) begin
        if (rst_n && ct_wren) begin
            logic [15:0] e;
            ct_writes++;
            if (sb.size() == 0) begin
                assertions++;
                failures++;
                $display("FAIL ct_unexpected: got write addr %0h data %0h, expected none",
                         ct_addr, ct_wrdata);
            end else begin
                e = sb.pop_front();
                check("ct_write", {16'h0, ct_addr, ct_wrdata}, {16'h0, e});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         init_bad;
        int         n;
        int         nbad;
        string      hello;
        rst_n = 1'b0;
        en    = 1'b0;
        key   = 24'h0;
        for (int i = 0; i < 256; i++) pt_img[i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rdy",       {31'h0, rdy},     32'h1);
        check("rst_s_wren",    {31'h0, s_wren},  32'h0);
        check("rst_ct_wren",   {31'h0, ct_wren}, 32'h0);
        check("rst_s_addr",    {24'h0, s_addr},  32'h0);
        check("rst_s_wrdata",  {24'h0, s_wrdata},32'h0);
        check("rst_pt_addr",   {24'h0, pt_addr}, 32'h0);
        check("rst_ct_addr",   {24'h0, ct_addr}, 32'h0);
        check("rst_ct_wrdata", {24'h0, ct_wrdata},32'h0);
`ifdef ARC4_PRINTABLE_CHK_EN
        check("rst_pt_ok",     {31'h0, pt_ok},   32'h1);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Empty message: only ct[0]=0
        setup_job(24'h000018, 0);
        start_job();
        wait_done("empty_done", 5000);
        check("empty_writes", ct_writes, 1);
        check("empty_sb", sb.size(), 0);

        // "hello"
        hello = "hello";
        for (int i = 0; i < 5; i++) pt_img[i+1] = hello[i];
        setup_job(24'h000018, 5);
        start_job();
        wait_done("hello_done", 5000);
        check("hello_writes", ct_writes, 6);
        check("hello_sb", sb.size(), 0);

        // INIT timing and post-KSA S contents
        pt_img[1] = 8'h48;
        pt_img[2] = 8'h69;
        setup_job(24'h1E4600, 2);
        start_job();
        init_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!(s_wren === 1'b1 && s_addr === 8'(i) && s_wrdata === 8'(i))) init_bad++;
        end
        check("init_seq", init_bad, 0);
        @(negedge clk);
        check("init_end_wren", {31'h0, s_wren}, 32'h0);
        n = 0;
        while (!ct_wren && n < 5000) begin
            @(negedge clk);
            n++;
        end
        nbad = 0;
        for (int i = 0; i < 256; i++) if (s_mem[i] !== m_ksa[i]) nbad++;
        check("ksa_s_image", nbad, 0);
        wait_done("ksa_done", 5000);
        check("ksa_sb", sb.size(), 0);

        // Maximum length: k runs to 255
        for (int i = 1; i < 256; i++) pt_img[i] = 8'($urandom_range(0, 255));
        setup_job(24'hA5C3F0, 255);
        start_job();
        wait_done("max_done", 8000);
        check("max_writes", ct_writes, 256);
        check("max_sb", sb.size(), 0);

        // en held high for the whole job: exactly one job
        for (int i = 0; i < 5; i++) pt_img[i+1] = hello[i];
        setup_job(24'h000018, 5);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("hold_rdy_low", {31'h0, rdy}, 32'h0);
        n = 0;
        while (!rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        check("hold_done", {31'h0, rdy}, 32'h1);
        check("hold_writes", ct_writes, 6);
        repeat (5) @(negedge clk);
        check("hold_no_restart", {31'h0, rdy}, 32'h1);
        check("hold_writes_after", ct_writes, 6);
        check("hold_sb", sb.size(), 0);

        // Reset asserted during PRGA at k=3 (on the S[i] write)
        setup_job(24'h000018, 5);
        start_job();
        n = 0;
        while (!(ct_wren && ct_addr == 8'd2) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_wren && n < 20);
        check("mid_in_wri", {31'h0, s_wren}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_s_wren", {31'h0, s_wren}, 32'h0);
        check("mid_ct_wren", {31'h0, ct_wren}, 32'h0);
        check("mid_rdy", {31'h0, rdy}, 32'h1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        setup_job(24'h000018, 5);
        start_job();
        wait_done("fresh_done", 5000);
        check("fresh_writes", ct_writes, 6);
        check("fresh_sb", sb.size(), 0);

`ifdef ARC4_PRINTABLE_CHK_EN
        pt_img[1] = 8'h41;
        pt_img[2] = 8'h0A;
        pt_img[3] = 8'h42;
        setup_job(24'h000018, 3);
        start_job();
        wait_done("pr_bad_done", 5000);
        check("pr_bad_pt_ok", {31'h0, pt_ok}, 32'h0);
        pt_img[2] = 8'h42;
        pt_img[3] = 8'h43;
        setup_job(24'h000018, 3);
        start_job();
        wait_done("pr_ok_done", 5000);
        check("pr_ok_pt_ok", {31'h0, pt_ok}, 32'h1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire
